// File: rtl/multicycle_control_fsm_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm_if
//
// Bundle between the multicycle control unit and the datapath.
//   Datapath -> control : inst (IR contents), zero (ALU zero flag)
//   Control -> datapath : register enables, memory strobes and mux selects
//
// Modports:
//   master - the control unit (reads inst/zero, drives every control line)
//   slave  - the datapath (drives inst/zero, consumes the control lines)
// -----------------------------------------------------------------------------
interface multicycle_control_fsm_if;
  logic [31:0] inst;
  logic        zero;

  logic        pc_write;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        i_or_d;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_source;
  logic [3:0]  alu_control;

  modport master (
    input  inst, zero,
    output pc_write, ir_write, mem_read, mem_write, reg_write,
           i_or_d, mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_control
  );

  modport slave (
    output inst, zero,
    input  pc_write, ir_write, mem_read, mem_write, reg_write,
           i_or_d, mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_control
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main control unit of the multicycle RV32I-subset datapath (lw, sw, add, sub,
// and, or, addi, andi, ori, beq). One state per cycle through fetch, decode,
// execute, memory and writeback; also decodes the ALU operation and keeps a
// retired-instruction counter for debug.
//
// Ports:
//   clk         - clock, all state updates on the rising edge
//   reset       - asynchronous active-low reset (0 = held in FETCH)
//   ctrl        - master side of multicycle_control_fsm_if (inst/zero in,
//                 all enables, strobes and mux selects out)
//   state       - current state encoding (debug)
//   instr_count - retired supported instructions, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_control_fsm_if.master ctrl,
  output logic [3:0]               state,
  output logic [CNT_W-1:0]         instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Instruction fields. IR is only written in FETCH, so these stay stable
  // for the rest of the instruction.
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       funct_ok;
  logic       unused_inst_bits;

  assign opcode   = ctrl.inst[6:0];
  assign funct3   = ctrl.inst[14:12];
  assign funct7b5 = ctrl.inst[30];
  // Only add/sub (000), or (110) and and (111) exist in this subset, for both
  // the R-type and I-type groups.
  assign funct_ok = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);
  assign unused_inst_bits = ^{ctrl.inst[31], ctrl.inst[29:15], ctrl.inst[11:7]};

  // funct7b5 selects SUB only for R-type; for I-type it is immediate data.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic       f7b5,
                                            input logic       is_r);
    case (f3)
      3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  state_t state_q, state_d;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  logic       pc_write, ir_write, mem_read, mem_write, reg_write;
  logic       i_or_d, mem_to_reg, alu_src_a, pc_source;
  logic [1:0] alu_src_b;
  logic [3:0] alu_control;

  // NOTE: every output and next_state gets a default before the case, so no
  // path through the block leaves a variable unassigned (no inferred latch).
  always_comb begin
    state_d     = S_FETCH;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    i_or_d      = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_source   = 1'b0;
    alu_control = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        // PC <= PC + 4 while the instruction is read into IR.
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively form the branch target: PC is already PC+4 here.
        alu_src_b = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_R:              state_d = funct_ok ? S_EXEC_R : S_FETCH;
          OP_I:              state_d = funct_ok ? S_EXEC_I : S_FETCH;
          OP_BRANCH:         state_d = (funct3 == 3'b000) ? S_BRANCH : S_FETCH;
          default:           state_d = S_FETCH;
        endcase
      end
      // ALUOut reloads every cycle, so the memory states keep the address
      // computation selected to hold the address stable.
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        i_or_d    = 1'b1;
        mem_read  = 1'b1;
        state_d   = S_MEM_WB;
      end
      S_MEM_WB: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b00;
        alu_control = alu_decode(funct3, funct7b5, 1'b1);
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = alu_decode(funct3, funct7b5, 1'b0);
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        // Repeat whichever execute state we came from, keyed off the opcode.
        alu_src_a = 1'b1;
        if (opcode == OP_R) begin
          alu_src_b   = 2'b00;
          alu_control = alu_decode(funct3, funct7b5, 1'b1);
        end else begin
          alu_src_b   = 2'b10;
          alu_control = alu_decode(funct3, funct7b5, 1'b0);
        end
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        // Only Mealy output: take the branch when A - B == 0.
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b00;
        alu_control = ALU_SUB;
        pc_source   = 1'b1;
        pc_write    = ctrl.zero;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // The state register is already in FETCH during reset; this also keeps
    // FETCH's enables from writing PC/IR/memory while reset is asserted.
    if (!reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign ctrl.pc_write    = pc_write;
  assign ctrl.ir_write    = ir_write;
  assign ctrl.mem_read    = mem_read;
  assign ctrl.mem_write   = mem_write;
  assign ctrl.reg_write   = reg_write;
  assign ctrl.i_or_d      = i_or_d;
  assign ctrl.mem_to_reg  = mem_to_reg;
  assign ctrl.alu_src_a   = alu_src_a;
  assign ctrl.alu_src_b   = alu_src_b;
  assign ctrl.pc_source   = pc_source;
  assign ctrl.alu_control = alu_control;
  assign state            = state_q;

  // Every final state of a supported instruction returns to FETCH, so the
  // edge leaving it is the retire point.
  logic retire;
  assign retire = (state_q == S_MEM_WB) || (state_q == S_MEM_WRITE) ||
                  (state_q == S_ALU_WB) || (state_q == S_BRANCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      instr_count <= '0;
    else if (retire) instr_count <= instr_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Directed bench for multicycle_control_fsm. Outputs are sampled on the
// falling clock edge; instructions are presented while the FSM is in FETCH
// so they are "in IR" from DECODE onward.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_count = '0;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .ctrl        (bus),
    .state       (state),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    bus.inst = 32'h0000_0000;
    bus.zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (state !== 4'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (instr_count !== 32'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", instr_count); end
    checks++; if ({bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write} !== 5'b00000) begin
      failures++; $display("FAIL rst_enables got=%b exp=00000",
        {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write}); end
    checks++; if (bus.alu_src_b !== 2'b01 || bus.alu_control !== 4'b0010) begin
      failures++; $display("FAIL rst_fetch_sel got=%b/%b exp=01/0010", bus.alu_src_b, bus.alu_control); end
    reset = 1'b1;
    #1;
    checks++; if ({bus.pc_write, bus.ir_write, bus.mem_read} !== 3'b111) begin
      failures++; $display("FAIL fetch_after_rst got=%b exp=111", {bus.pc_write, bus.ir_write, bus.mem_read}); end
    checks++; if (bus.i_or_d !== 1'b0 || bus.alu_src_a !== 1'b0 || bus.pc_source !== 1'b0) begin
      failures++; $display("FAIL fetch_sel got=%b%b%b exp=000", bus.i_or_d, bus.alu_src_a, bus.pc_source); end
  endtask

  task automatic test_addi();
    logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd7, 4'd8};
    bus.inst = 32'h0c80_0093;
    for (int i = 0; i < 4; i++) begin
      checks++; if (state !== seq[i]) begin failures++; $display("FAIL addi_state[%0d] got=%0d exp=%0d", i, state, seq[i]); end
      if (i >= 2) begin
        checks++; if (bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b10 || bus.alu_control !== 4'b0010) begin
          failures++; $display("FAIL addi_alu[%0d] got=%b/%b/%b exp=1/10/0010", i, bus.alu_src_a, bus.alu_src_b, bus.alu_control); end
      end
      if (i == 3) begin
        checks++; if (bus.reg_write !== 1'b1 || bus.mem_to_reg !== 1'b0) begin
          failures++; $display("FAIL addi_wb got=%b%b exp=10", bus.reg_write, bus.mem_to_reg); end
      end
      step();
    end
    exp_count++;
    checks++; if (state !== 4'd0) begin failures++; $display("FAIL addi_end_state got=%0d exp=0", state); end
    checks++; if (instr_count !== exp_count) begin failures++; $display("FAIL addi_count got=%0d exp=%0d", instr_count, exp_count); end
  endtask

  task automatic test_lw();
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    bus.inst = 32'hfce0_a103;
    for (int i = 0; i < 5; i++) begin
      checks++; if (state !== seq[i]) begin failures++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, seq[i]); end
      if (i >= 2) begin
        checks++; if (bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b10 || bus.alu_control !== 4'b0010) begin
          failures++; $display("FAIL lw_addr_hold[%0d] got=%b/%b/%b exp=1/10/0010", i, bus.alu_src_a, bus.alu_src_b, bus.alu_control); end
      end
      if (i == 3) begin
        checks++; if (bus.i_or_d !== 1'b1 || bus.mem_read !== 1'b1 || bus.reg_write !== 1'b0) begin
          failures++; $display("FAIL lw_memread got=%b%b%b exp=110", bus.i_or_d, bus.mem_read, bus.reg_write); end
      end
      if (i == 4) begin
        checks++; if (bus.mem_to_reg !== 1'b1 || bus.reg_write !== 1'b1) begin
          failures++; $display("FAIL lw_wb got=%b%b exp=11", bus.mem_to_reg, bus.reg_write); end
      end
      step();
    end
    exp_count++;
    checks++; if (state !== 4'd0) begin failures++; $display("FAIL lw_end_state got=%0d exp=0", state); end
    checks++; if (instr_count !== exp_count) begin failures++; $display("FAIL lw_count got=%0d exp=%0d", instr_count, exp_count); end
  endtask

  task automatic test_sw();
    logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    bus.inst = 32'hfe30_a623;
    for (int i = 0; i < 4; i++) begin
      checks++; if (state !== seq[i]) begin failures++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, state, seq[i]); end
      checks++; if (bus.mem_write !== (i == 3) || bus.reg_write !== 1'b0) begin
        failures++; $display("FAIL sw_strobes[%0d] got=mw%b rw%b exp=mw%b rw0", i, bus.mem_write, bus.reg_write, (i == 3)); end
      if (i == 3) begin
        checks++; if (bus.i_or_d !== 1'b1 || bus.alu_src_b !== 2'b10) begin
          failures++; $display("FAIL sw_addr got=%b/%b exp=1/10", bus.i_or_d, bus.alu_src_b); end
      end
      step();
    end
    exp_count++;
    checks++; if (instr_count !== exp_count) begin failures++; $display("FAIL sw_count got=%0d exp=%0d", instr_count, exp_count); end
  endtask

  // sub then or issued back to back; funct decode in EXEC_R and held in ALU_WB.
  task automatic test_back_to_back();
    logic [31:0] insts [2] = '{32'h4020_8133, 32'h0020_e133};
    logic [3:0]  alu   [2] = '{4'b0110, 4'b0001};
    for (int k = 0; k < 2; k++) begin
      bus.inst = insts[k];
      checks++; if (state !== 4'd0) begin failures++; $display("FAIL r%0d_fetch got=%0d exp=0", k, state); end
      step();
      step();
      checks++; if (state !== 4'd6) begin failures++; $display("FAIL r%0d_exec_state got=%0d exp=6", k, state); end
      checks++; if (bus.alu_control !== alu[k] || bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b00) begin
        failures++; $display("FAIL r%0d_exec_alu got=%b/%b/%b exp=%b/1/00", k, bus.alu_control, bus.alu_src_a, bus.alu_src_b, alu[k]); end
      step();
      checks++; if (state !== 4'd8 || bus.reg_write !== 1'b1 || bus.alu_control !== alu[k]) begin
        failures++; $display("FAIL r%0d_wb got=s%0d rw%b alu%b exp=s8 rw1 alu%b", k, state, bus.reg_write, bus.alu_control, alu[k]); end
      step();
      exp_count++;
    end
    checks++; if (instr_count !== exp_count) begin failures++; $display("FAIL r_count got=%0d exp=%0d", instr_count, exp_count); end
  endtask

  task automatic test_beq();
    // Taken: zero=1.
    bus.inst = 32'h0000_0063;
    bus.zero = 1'b1;
    step();
    checks++; if (state !== 4'd1 || bus.alu_src_b !== 2'b10) begin
      failures++; $display("FAIL beq_decode got=s%0d b%b exp=s1 b10", state, bus.alu_src_b); end
    step();
    checks++; if (state !== 4'd9) begin failures++; $display("FAIL beq_state got=%0d exp=9", state); end
    checks++; if (bus.pc_write !== 1'b1 || bus.pc_source !== 1'b1 || bus.alu_control !== 4'b0110) begin
      failures++; $display("FAIL beq_taken got=pw%b ps%b alu%b exp=pw1 ps1 alu0110", bus.pc_write, bus.pc_source, bus.alu_control); end
    // pc_write follows zero combinationally within the BRANCH cycle.
    bus.zero = 1'b0;
    #1;
    checks++; if (bus.pc_write !== 1'b0) begin failures++; $display("FAIL beq_mealy got=%b exp=0", bus.pc_write); end
    step();
    exp_count++;
    checks++; if (state !== 4'd0 || instr_count !== exp_count) begin
      failures++; $display("FAIL beq_end got=s%0d c%0d exp=s0 c%0d", state, instr_count, exp_count); end
    // Not taken: zero=0 throughout.
    step();
    step();
    checks++; if (state !== 4'd9 || bus.pc_write !== 1'b0 || bus.pc_source !== 1'b1) begin
      failures++; $display("FAIL beq_nt got=s%0d pw%b ps%b exp=s9 pw0 ps1", state, bus.pc_write, bus.pc_source); end
    step();
    exp_count++;
    checks++; if (instr_count !== exp_count) begin failures++; $display("FAIL beq_nt_count got=%0d exp=%0d", instr_count, exp_count); end
  endtask

  task automatic test_unsupported();
    logic [31:0] insts [3] = '{32'h0000_007f, 32'h0000_1063, 32'h0000_2033};
    for (int k = 0; k < 3; k++) begin
      bus.inst = insts[k];
      step();
      checks++; if (state !== 4'd1) begin failures++; $display("FAIL nop%0d_decode got=%0d exp=1", k, state); end
      step();
      checks++; if (state !== 4'd0) begin failures++; $display("FAIL nop%0d_return got=%0d exp=0", k, state); end
    end
    checks++; if (instr_count !== exp_count) begin failures++; $display("FAIL nop_count got=%0d exp=%0d", instr_count, exp_count); end
  endtask

  task automatic test_reset_mid();
    bus.inst = 32'hfce0_a103;
    step();
    step();
    step();
    checks++; if (state !== 4'd3) begin failures++; $display("FAIL mid_pre got=%0d exp=3", state); end
    reset = 1'b0;
    #1;
    checks++; if (state !== 4'd0 || bus.reg_write !== 1'b0 || bus.pc_write !== 1'b0) begin
      failures++; $display("FAIL mid_async got=s%0d rw%b pw%b exp=s0 rw0 pw0", state, bus.reg_write, bus.pc_write); end
    checks++; if (instr_count !== 32'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", instr_count); end
    exp_count = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (state !== 4'd0 || bus.reg_write !== 1'b0) begin
      failures++; $display("FAIL mid_release got=s%0d rw%b exp=s0 rw0", state, bus.reg_write); end
    @(negedge clk);
    checks++; if (state !== 4'd1) begin failures++; $display("FAIL mid_restart got=%0d exp=1", state); end
    step();
    step();
    step();
    step();
    exp_count++;
    checks++; if (state !== 4'd0 || instr_count !== exp_count) begin
      failures++; $display("FAIL mid_complete got=s%0d c%0d exp=s0 c%0d", state, instr_count, exp_count); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw();
    test_sw();
    test_back_to_back();
    test_beq();
    test_unsupported();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
